chirp_inc_gen: RTL and testbench
================================

Name: chirp_inc_gen

Overview:
- Per-sample phase-increment generator for the LoRa TX chain; drives the phaseIn input of the phase-accumulator stage directly.
- Accepts one symbol descriptor per handshake: symbol value, SF and chirp type.
- Emits the linear-frequency-chirp increment sequence for that symbol, one increment per sample-enable, in the accumulator's fixed-point scale, where SCALE_2X represents one full cycle (2π).
- Back-to-back symbols stream with no gap.

Parameters:
PRECISION, 24, signed width of phaseInc; must match the accumulator width.
SCALE_2X, 2^(PRECISION-2), fixed-point value of one full phase cycle.
LOG2_OSR, 2, log2 of samples per chip (OSR = 4).

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
sampleEn  input  1  sample strobe; state advances only when high.
symValid  input  1  symbol descriptor valid.
symReady  output  1  descriptor accepted on cycles where symValid & symReady.
symVal  input  12  symbol value; bits at and above SF ignored.
symSF  input  4  spreading factor; <7 treated as 7, >12 as 12.
symType  input  2  0 = upchirp, 1 = downchirp, 2 = quarter downchirp, 3 = upchirp.
incValid  output  1  phaseInc valid.
phaseInc  output  PRECISION  signed per-sample phase increment.
symStart  output  1  first sample of a symbol is presented.
symLast  output  1  last sample of a symbol is presented.

Behaviour:
- Reset (sync, any state, including mid-symbol): state IDLE; incValid, symStart, symLast = 0; phaseInc = 0; the current symbol is discarded.
- Latched registers: k (chip bin, SF bits), ovs (LOG2_OSR bits), chipCnt, sf, type. step = SCALE_2X >> (sf + LOG2_OSR), an exact power of two.
- IDLE:
  - symReady = 1 (independent of sampleEn). incValid = 0 and phaseInc = 0.
  - On accept: k = symVal mod 2^sf, ovs = 0, chipCnt = 0. Go to RUN.
  - The first sample is presented the next cycle.
- RUN:
  - incValid = 1.
  - phaseInc = (k - 2^(sf-1)) * step for upchirp; the negation of that for types 1 and 2. Computed from registers.
  - symStart = (chipCnt == 0 && ovs == 0). symLast = (chipCnt == len-1 && ovs == OSR-1).
  - len = 2^sf for types 0, 1 and 3; 2^sf / 4 for type 2.
- Sample consumption: the downstream stage consumes a sample on each RUN cycle with sampleEn = 1. On that edge:
  - ovs increments.
  - On ovs wrap: k = (k+1) mod 2^sf (wrap-around from 2^sf-1 to 0), and chipCnt increments.
- sampleEn = 0: all state and outputs hold; no advance, no accept in RUN.
- symReady in RUN = symLast & sampleEn.
  - If symValid is high on that edge: load the new descriptor and stay in RUN. The next cycle presents sample 0 of the new symbol (zero-gap streaming).
  - If symValid is low: go to IDLE (underflow); incValid drops the next cycle.
- Width: |phaseInc| ≤ SCALE_2X / (2·OSR); no overflow in PRECISION bits. Multiply implemented as a shift of the signed bin offset.
- Descriptor inputs are sampled only at acceptance; changes at other times are ignored.

Test Plan:
- Parameters used throughout: PRECISION = 24, SCALE_2X = 4194304, OSR = 4, sampleEn tied high. SF7 gives step = 8192.
- Upchirp, SF7, symVal 0 → first phaseInc = -524288 held 4 cycles, then -516096; final chip 516096; exactly 512 incValid cycles; symStart on cycle 1 only, symLast on cycle 512 only; then IDLE.
- Upchirp, SF7, symVal 100 → starts at 294912; after 28 chips (112 samples) wraps to -524288; total 512 samples.
- Downchirp, symVal 0, followed back-to-back by quarter downchirp → +524288 first; symReady high exactly on sample 512; next cycle sample 0 of the quarter chirp = +524288; the quarter chirp lasts 128 samples.
- SF12, symVal 4095 → step = 256; first phaseInc = 2047·256 = 524032; next chip -524288.
- sampleEn toggled 1-of-3 cycles → values identical to the sampleEn-high sequence, each held 3× longer; no accept while sampleEn = 0.
- rst asserted at sample 200 with symValid high → next cycle incValid = 0, phaseInc = 0, symReady = 1; a new symbol then starts cleanly from sample 0.

Source files
------------

// File: rtl/chirp_inc_gen.sv
// chirp_inc_gen: per-sample phase-increment generator for the LoRa TX chain.
// Takes one symbol descriptor per handshake. For that symbol it emits the
// linear-chirp increment sequence, one increment per consumed sample. The
// output feeds the phase accumulator directly.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no symbol loaded; symReady high, incValid low
// ST_RUN   | presenting samples of the latched symbol; reload on last
module chirp_inc_gen #(
    parameter int PRECISION = 24,
    parameter int SCALE_2X  = 2 ** (PRECISION - 2),
    parameter int LOG2_OSR  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sampleEn,
    input  logic                        symValid,
    output logic                        symReady,
    input  logic [11:0]                 symVal,
    input  logic [3:0]                  symSF,
    input  logic [1:0]                  symType,
    output logic                        incValid,
    output logic signed [PRECISION-1:0] phaseInc,
    output logic                        symStart,
    output logic                        symLast
);

    // One chip of bin offset is worth SCALE_2X >> (sf + LOG2_OSR). That is a
    // power of two, so the multiply reduces to a left shift by
    // SHIFT_BASE - sf.
    localparam int SHIFT_BASE = $clog2(SCALE_2X) - LOG2_OSR;
    localparam int SF_MIN     = 7;
    localparam int SF_MAX     = 12;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [11:0]           k_q, k_d;
    logic [LOG2_OSR-1:0]   ovs_q, ovs_d;
    logic [11:0]           chip_cnt_q, chip_cnt_d;
    logic [3:0]            sf_q, sf_d;
    logic [1:0]            type_q, type_d;

    logic [3:0]            sf_in;
    logic [11:0]           in_mask;
    logic [11:0]           cur_mask;
    logic [11:0]           last_chip;
    logic [12:0]           half_bin;
    logic signed [12:0]    bin_off;
    logic signed [PRECISION-1:0] off_ext;
    logic [5:0]            shamt;
    logic signed [PRECISION-1:0] up_inc;
    logic signed [PRECISION-1:0] chirp_inc;
    logic                  run;
    logic                  neg_chirp;
    logic                  last_sample;
    logic                  load;

    // Clamp the incoming SF and build the bin masks and chip-count limit.
    always_comb begin
        if (symSF < 4'(SF_MIN)) begin
            sf_in = 4'(SF_MIN);
        end else if (symSF > 4'(SF_MAX)) begin
            sf_in = 4'(SF_MAX);
        end else begin
            sf_in = symSF;
        end
        in_mask  = 12'((13'd1 << sf_in) - 13'd1);
        cur_mask = 12'((13'd1 << sf_q) - 13'd1);
        // The quarter downchirp runs a quarter of the chips of a full symbol.
        if (type_q == 2'd2) begin
            last_chip = 12'((13'd1 << (sf_q - 4'd2)) - 13'd1);
        end else begin
            last_chip = cur_mask;
        end
    end

    // Bin offset times the step, done as a shift; negated for down/quarter chirps.
    always_comb begin
        half_bin  = 13'd1 << (sf_q - 4'd1);
        bin_off   = $signed({1'b0, k_q}) - $signed(half_bin);
        off_ext   = {{(PRECISION - 13){bin_off[12]}}, bin_off};
        shamt     = 6'(SHIFT_BASE) - {2'b00, sf_q};
        up_inc    = off_ext <<< shamt;
        neg_chirp = (type_q == 2'd1) || (type_q == 2'd2);
        chirp_inc = neg_chirp ? -up_inc : up_inc;
    end

    // Output decode from the registered state.
    always_comb begin
        run         = (state_q == ST_RUN);
        last_sample = (chip_cnt_q == last_chip) && (ovs_q == '1);
        incValid    = run;
        phaseInc    = run ? chirp_inc : '0;
        symStart    = run && (chip_cnt_q == 12'd0) && (ovs_q == '0);
        symLast     = run && last_sample;
        symReady    = run ? (last_sample && sampleEn) : 1'b1;
    end

    // Next-state logic: accept, per-sample advance, reload or underflow to idle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ovs_d      = ovs_q;
        chip_cnt_d = chip_cnt_q;
        sf_d       = sf_q;
        type_d     = type_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (symValid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sampleEn) begin
                    if (last_sample) begin
                        if (symValid) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ovs_d = ovs_q + LOG2_OSR'(1);
                        if (ovs_q == '1) begin
                            k_d        = (k_q + 12'd1) & cur_mask;
                            chip_cnt_d = chip_cnt_q + 12'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            k_d        = symVal & in_mask;
            ovs_d      = '0;
            chip_cnt_d = 12'd0;
            sf_d       = sf_in;
            type_d     = symType;
        end
    end

    // State registers; reset drops any symbol in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= 12'd0;
            ovs_q      <= '0;
            chip_cnt_q <= 12'd0;
            sf_q       <= 4'(SF_MIN);
            type_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ovs_q      <= ovs_d;
            chip_cnt_q <= chip_cnt_d;
            sf_q       <= sf_d;
            type_q     <= type_d;
        end
    end

endmodule

// File: tb/tb_chirp_inc_gen.sv
// Testbench for chirp_inc_gen: a table of single symbols plus hand-written
// back-to-back, sampleEn-throttled and reset-mid-symbol sequences, all
// checked against a reference-model scoreboard.
module tb_chirp_inc_gen;

    localparam int PRECISION = 24;
    localparam int SCALE_2X  = 4194304;
    localparam int OSR       = 4;

    logic                        clk;
    logic                        rst;
    logic                        sampleEn;
    logic                        symValid;
    logic                        symReady;
    logic [11:0]                 symVal;
    logic [3:0]                  symSF;
    logic [1:0]                  symType;
    logic                        incValid;
    logic signed [PRECISION-1:0] phaseInc;
    logic                        symStart;
    logic                        symLast;

    chirp_inc_gen #(.PRECISION(PRECISION), .LOG2_OSR(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sampleEn (sampleEn),
        .symValid (symValid),
        .symReady (symReady),
        .symVal   (symVal),
        .symSF    (symSF),
        .symType  (symType),
        .incValid (incValid),
        .phaseInc (phaseInc),
        .symStart (symStart),
        .symLast  (symLast)
    );

    typedef struct {
        int   inc;
        logic start;
        logic last;
    } exp_t;

    typedef struct {
        int sf;
        int val;
        int typ;
        int first;
        int nsamp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[7];

    int total = 0;
    int bad   = 0;
    int n_cons;
    int n_valid;
    int first_seen;
    bit mon_en    = 0;
    bit en_toggle = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-sample increment as a product with the step size.
    task automatic push_sym(input int sf_in, input int val, input int typ);
        int sf, n, len, step, chip, k, inc, ns;
        sf   = (sf_in < 7) ? 7 : (sf_in > 12) ? 12 : sf_in;
        n    = 1 << sf;
        len  = (typ == 2) ? n / 4 : n;
        step = SCALE_2X / (n * OSR);
        ns   = len * OSR;
        for (int s = 0; s < ns; s++) begin
            exp_t e;
            chip = s / OSR;
            k    = ((val % n) + chip) % n;
            inc  = (k - n / 2) * step;
            if (typ == 1 || typ == 2) inc = -inc;
            e.inc   = inc;
            e.start = (s == 0);
            e.last  = (s == ns - 1);
            q.push_back(e);
        end
    endtask

    task automatic drive_desc(input int sf, input int val, input int typ);
        symValid = 1'b1;
        symSF    = 4'(sf);
        symVal   = 12'(val);
        symType  = 2'(typ);
        push_sym(sf, val, typ);
    endtask

    task automatic send(input int sf, input int val, input int typ);
        tick();
        drive_desc(sf, val, typ);
        tick();
        symValid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((q.size() != 0 || incValid) && c < budget) begin
            tick();
            c++;
        end
        check("drain_timeout", longint'(c >= budget), 0);
    endtask

    // sampleEn driver: high, or one cycle in three when throttling.
    initial begin
        int ph = 0;
        sampleEn = 1'b1;
        forever begin
            tick();
            if (en_toggle) begin
                sampleEn = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                sampleEn = 1'b1;
            end
        end
    end

    // Monitor: compare every cycle on the falling edge; pop on consumed samples.
    always @(negedge clk) begin
        if (mon_en) begin
            if (incValid) begin
                n_valid++;
                if (q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    check("phaseInc", phaseInc, q[0].inc);
                    check("symStart", symStart, q[0].start);
                    check("symLast", symLast, q[0].last);
                    check("symReady_run", symReady, q[0].last && sampleEn);
                    if (sampleEn) begin
                        if (q[0].start) first_seen = phaseInc;
                        n_cons++;
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("idle_phaseInc", phaseInc, 0);
                check("idle_symReady", symReady, 1);
                check("idle_symStart", symStart, 0);
                check("idle_symLast", symLast, 0);
            end
        end
    end

    initial begin
        int cnt;
        vecs[0] = '{sf: 7,  val: 0,     typ: 0, first: -524288, nsamp: 512};
        vecs[1] = '{sf: 7,  val: 100,   typ: 0, first: 294912,  nsamp: 512};
        vecs[2] = '{sf: 12, val: 4095,  typ: 0, first: 524032,  nsamp: 16384};
        vecs[3] = '{sf: 7,  val: 0,     typ: 1, first: 524288,  nsamp: 512};
        vecs[4] = '{sf: 7,  val: 0,     typ: 2, first: 524288,  nsamp: 128};
        vecs[5] = '{sf: 5,  val: 12'h3FF, typ: 3, first: 516096, nsamp: 512};
        vecs[6] = '{sf: 15, val: 0,     typ: 0, first: -524288, nsamp: 16384};

        rst      = 1'b1;
        symValid = 1'b0;
        symVal   = 12'd0;
        symSF    = 4'd7;
        symType  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_incValid", incValid, 0);
        check("rst_phaseInc", phaseInc, 0);
        check("rst_symStart", symStart, 0);
        check("rst_symLast", symLast, 0);
        check("rst_symReady", symReady, 1);
        rst    = 1'b0;
        mon_en = 1;

        // Single symbols from the table.
        for (int i = 0; i < 7; i++) begin
            n_cons = 0;
            n_valid = 0;
            first_seen = 12345;
            send(vecs[i].sf, vecs[i].val, vecs[i].typ);
            drain(20000);
            check("vec_first", first_seen, vecs[i].first);
            check("vec_nsamp", n_cons, vecs[i].nsamp);
            check("vec_nvalid", n_valid, vecs[i].nsamp);
        end

        // Downchirp followed back-to-back by a quarter downchirp.
        tick();
        drive_desc(7, 0, 1);
        tick();
        drive_desc(7, 0, 2);
        cnt = 0;
        while (!symReady && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("b2b_ready_sample", cnt, 511);
        check("b2b_ready_last", symLast, 1);
        tick();
        symValid = 1'b0;
        check("b2b_next_valid", incValid, 1);
        check("b2b_next_start", symStart, 1);
        check("b2b_next_inc", phaseInc, 524288);
        n_cons = 0;
        drain(2000);
        check("b2b_quarter_len", n_cons, 128);

        // Throttled sampleEn, one cycle in three, with a queued second symbol.
        en_toggle = 1;
        n_cons = 0;
        tick();
        drive_desc(7, 100, 0);
        tick();
        drive_desc(7, 3, 3);
        cnt = 0;
        while (cnt < 5000) begin
            tick();
            #1;
            cnt++;
            if (symReady) begin
                tick();
                symValid = 1'b0;
                break;
            end
        end
        check("toggle_accept_timeout", longint'(cnt >= 5000), 0);
        drain(8000);
        check("toggle_nsamp", n_cons, 1024);
        en_toggle = 0;
        tick();

        // Reset in the middle of a symbol with a descriptor offered.
        n_cons = 0;
        send(7, 0, 0);
        cnt = 0;
        while (n_cons < 200 && cnt < 1000) begin
            tick();
            cnt++;
        end
        check("rst_mid_reach", n_cons, 200);
        rst = 1'b1;
        symValid = 1'b1;
        symVal = 12'd5;
        tick();
        q.delete();
        check("rst_mid_incValid", incValid, 0);
        check("rst_mid_phaseInc", phaseInc, 0);
        check("rst_mid_symReady", symReady, 1);
        rst = 1'b0;
        symValid = 1'b0;
        tick();
        n_cons = 0;
        first_seen = 12345;
        send(7, 0, 0);
        drain(2000);
        check("rst_after_first", first_seen, -524288);
        check("rst_after_nsamp", n_cons, 512);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
